// File: rtl/proc_pkg.sv
// Shared processor definitions: default widths, fetch FSM encoding and read destination.
package proc_pkg;

   localparam int unsigned DEF_BUS_WIDTH  = 16;
   localparam int unsigned DEF_ADDR_WIDTH = 8;
   localparam int unsigned DEF_RESET_PC   = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_e;

   typedef enum logic {
      DEST_IR  = 1'b0,
      DEST_OPR = 1'b1
   } dest_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Request/acknowledge read port between the fetch stage and instruction memory.
interface fetch_unit_if #(
   parameter int unsigned BUS_WIDTH  = 16,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [BUS_WIDTH-1:0]  imem_rdata;
   logic                  imem_ack;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ack
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ack
   );
endinterface

// File: rtl/pc_reg.sv
// Program counter: increment with wrap, or conditional jump to the operand target.
module pc_reg #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned RESET_PC   = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_enable,
   input  logic                  i_pc_inc,
   input  logic                  i_jump,
   input  logic                  i_alu_zero,
   input  logic [ADDR_WIDTH-1:0] i_jump_target,
   output logic [ADDR_WIDTH-1:0] o_pc
);

   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;

   // A taken jump needs a non-zero ALU result; otherwise pc_inc just advances.
   always_comb begin
      w_pc_nxt = r_pc;
      if (i_pc_inc) begin
         if (i_jump && !i_alu_zero) begin
            w_pc_nxt = i_jump_target;
         end else begin
            w_pc_nxt = r_pc + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pc <= ADDR_WIDTH'(RESET_PC);
      end else if (i_enable) begin
         r_pc <= w_pc_nxt;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, IR and OPR and runs the instruction-memory read handshake.
module fetch_unit
   import proc_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = DEF_BUS_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned RESET_PC   = DEF_RESET_PC
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  imem_read,
   input  logic                  opr_sel,
   input  logic                  pc_inc,
   input  logic                  jump,
   input  logic                  alu_zero,
   fetch_unit_if.master          imem,
   output logic [BUS_WIDTH-1:0]  ir,
   output logic [BUS_WIDTH-1:0]  opr,
   output logic                  ir_valid,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy,
   output logic                  overrun
);

   fetch_state_e          r_state,    w_state_nxt;
   dest_e                 r_dest,     w_dest_nxt;
   logic [BUS_WIDTH-1:0]  r_ir,       w_ir_nxt;
   logic [BUS_WIDTH-1:0]  r_opr,      w_opr_nxt;
   logic [ADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
   logic                  r_req,      w_req_nxt;
   logic                  r_busy,     w_busy_nxt;
   logic                  r_ir_valid, w_ir_valid_nxt;
   logic                  r_overrun,  w_overrun_nxt;
   logic [ADDR_WIDTH-1:0] w_pc;

   // Jump target comes from the registered OPR, so a same-edge OPR write is not seen.
   pc_reg #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_enable      (enable),
      .i_pc_inc      (pc_inc),
      .i_jump        (jump),
      .i_alu_zero    (alu_zero),
      .i_jump_target (r_opr[ADDR_WIDTH-1:0]),
      .o_pc          (w_pc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_dest     <= DEST_IR;
         r_ir       <= '0;
         r_opr      <= '0;
         r_addr     <= ADDR_WIDTH'(RESET_PC);
         r_req      <= 1'b0;
         r_busy     <= 1'b0;
         r_ir_valid <= 1'b0;
         r_overrun  <= 1'b0;
      end else if (enable) begin
         r_state    <= w_state_nxt;
         r_dest     <= w_dest_nxt;
         r_ir       <= w_ir_nxt;
         r_opr      <= w_opr_nxt;
         r_addr     <= w_addr_nxt;
         r_req      <= w_req_nxt;
         r_busy     <= w_busy_nxt;
         r_ir_valid <= w_ir_valid_nxt;
         r_overrun  <= w_overrun_nxt;
      end
   end

   // Next-state and next-output logic; acks seen in IDLE fall through unused.
   always_comb begin
      w_state_nxt    = r_state;
      w_dest_nxt     = r_dest;
      w_ir_nxt       = r_ir;
      w_opr_nxt      = r_opr;
      w_addr_nxt     = r_addr;
      w_req_nxt      = r_req;
      w_busy_nxt     = r_busy;
      w_ir_valid_nxt = 1'b0;
      w_overrun_nxt  = r_overrun;

      unique case (r_state)
         S_IDLE: begin
            if (imem_read) begin
               w_addr_nxt  = w_pc;
               w_dest_nxt  = dest_e'(opr_sel);
               w_req_nxt   = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_read) begin
               w_overrun_nxt = 1'b1;
            end
            if (imem.imem_ack) begin
               if (r_dest == DEST_OPR) begin
                  w_opr_nxt = imem.imem_rdata;
               end else begin
                  w_ir_nxt = imem.imem_rdata;
               end
               w_req_nxt      = 1'b0;
               w_busy_nxt     = 1'b0;
               w_ir_valid_nxt = 1'b1;
               w_state_nxt    = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign imem.imem_req  = r_req;
   assign imem.imem_addr = r_addr;
   assign ir             = r_ir;
   assign opr            = r_opr;
   assign ir_valid       = r_ir_valid;
   assign pc             = w_pc;
   assign busy           = r_busy;
   assign overrun        = r_overrun;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a transaction-level model.
module tb_fetch_unit;
   import proc_pkg::*;

   localparam int unsigned BW = 16;
   localparam int unsigned AW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, enable, imem_read, opr_sel, pc_inc, jump, alu_zero;
   logic [BW-1:0] ir, opr;
   logic          ir_valid, busy, overrun;
   logic [AW-1:0] pc;

   fetch_unit_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

   fetch_unit #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .RESET_PC(0)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .imem_read (imem_read),
      .opr_sel   (opr_sel),
      .pc_inc    (pc_inc),
      .jump      (jump),
      .alu_zero  (alu_zero),
      .imem      (bus),
      .ir        (ir),
      .opr       (opr),
      .ir_valid  (ir_valid),
      .pc        (pc),
      .busy      (busy),
      .overrun   (overrun)
   );

   logic [BW-1:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: one outstanding read at most, tracked as a pending transaction.
   logic [AW-1:0] m_pc;
   logic [BW-1:0] m_ir, m_opr;
   logic          m_valid, m_pending, m_dest, m_ovr;
   logic [AW-1:0] m_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit rst_i, input bit en_i, input bit rd_i, input bit sel_i,
                             input bit inc_i, input bit jmp_i, input bit az_i, input bit ack_i);
      logic [BW-1:0] old_opr;
      if (!rst_i) begin
         m_pc = 8'h00; m_ir = '0; m_opr = '0; m_valid = 0;
         m_pending = 0; m_dest = 0; m_ovr = 0; m_addr = 8'h00;
      end else if (en_i) begin
         old_opr = m_opr;
         m_valid = 0;
         if (m_pending) begin
            if (rd_i) m_ovr = 1;
            if (ack_i) begin
               if (m_dest) m_opr = mem[m_addr];
               else        m_ir  = mem[m_addr];
               m_pending = 0;
               m_valid   = 1;
            end
         end else if (rd_i) begin
            m_pending = 1;
            m_addr    = m_pc;
            m_dest    = sel_i;
         end
         if (inc_i) begin
            if (jmp_i && !az_i) m_pc = old_opr[AW-1:0];
            else                m_pc = m_pc + 8'd1;
         end
      end
   endtask

   task automatic step(input bit rst_i, input bit en_i, input bit rd_i, input bit sel_i,
                       input bit inc_i, input bit jmp_i, input bit az_i, input bit ack_i);
      reset_n        = rst_i;
      enable         = en_i;
      imem_read      = rd_i;
      opr_sel        = sel_i;
      pc_inc         = inc_i;
      jump           = jmp_i;
      alu_zero       = az_i;
      bus.imem_ack   = ack_i;
      bus.imem_rdata = ack_i ? mem[bus.imem_addr] : BW'($urandom);
      @(posedge clk);
      model_edge(rst_i, en_i, rd_i, sel_i, inc_i, jmp_i, az_i, ack_i);
      #1;
      chk("pc",        32'(pc),            32'(m_pc));
      chk("ir",        32'(ir),            32'(m_ir));
      chk("opr",       32'(opr),           32'(m_opr));
      chk("ir_valid",  32'(ir_valid),      32'(m_valid));
      chk("busy",      32'(busy),          32'(m_pending));
      chk("imem_req",  32'(bus.imem_req),  32'(m_pending));
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_addr));
      chk("overrun",   32'(overrun),       32'(m_ovr));
   endtask

   initial begin
      int wcnt;
      bit late_ack;
      bit r_n, en, rd, sel, inc, jmp, az, ack;
      logic [AW-1:0] pc_save;
      logic [BW-1:0] ir_save;

      for (int i = 0; i < 256; i++) mem[i] = BW'($urandom);
      mem[0] = 16'hA123;
      mem[1] = 16'h00FE;
      mem[2] = 16'h0040;

      // Reset and a single zero-wait fetch from address 0
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0, 0, 0);
      chk("reset_pc", 32'(pc), 32'h0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      chk("fetch0_addr", 32'(bus.imem_addr), 32'h0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      chk("fetch0_ir", 32'(ir), 32'hA123);
      chk("fetch0_valid", 32'(ir_valid), 32'h1);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      chk("fetch0_valid_drop", 32'(ir_valid), 32'h0);
      chk("fetch0_pc", 32'(pc), 32'h0);

      // Load OPR=0x00FE, jump there, then wrap the PC through 0xFF
      step(1, 1, 0, 0, 1, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 1, 1, 0, 0);
      chk("jump_fe", 32'(pc), 32'hFE);
      step(1, 1, 0, 0, 1, 0, 0, 0);
      chk("wrap_ff", 32'(pc), 32'hFF);
      step(1, 1, 0, 0, 1, 0, 0, 0);
      chk("wrap_00", 32'(pc), 32'h00);
      step(1, 1, 0, 0, 1, 0, 0, 0);
      chk("wrap_01", 32'(pc), 32'h01);

      // Conditional jump: taken when alu_zero=0, falls through when alu_zero=1
      step(1, 1, 0, 0, 1, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      chk("opr_40", 32'(opr), 32'h0040);
      step(1, 1, 0, 0, 1, 1, 0, 0);
      chk("jump_taken", 32'(pc), 32'h40);
      step(1, 1, 0, 0, 1, 1, 1, 0);
      chk("jump_not_taken", 32'(pc), 32'h41);

      // Wait-state read with pc_inc and a second read during the wait
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      chk("wait_addr", 32'(bus.imem_addr), 32'h41);
      chk("wait_overrun", 32'(overrun), 32'h1);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      chk("wait_ir", 32'(ir), 32'(mem[8'h41]));
      chk("wait_pc", 32'(pc), 32'h42);

      // Reset during WAIT, then a late ack that must be ignored
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      chk("late_ack_ir", 32'(ir), 32'h0);
      chk("late_ack_busy", 32'(busy), 32'h0);
      chk("late_ack_ovr", 32'(overrun), 32'h0);

      // Enable low freezes everything, then normal operation resumes
      step(1, 1, 0, 0, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      pc_save = pc;
      ir_save = ir;
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 0, 0, 0);
      chk("frozen_pc", 32'(pc), 32'(pc_save));
      chk("frozen_ir", 32'(ir), 32'(ir_save));
      step(1, 1, 1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      chk("reenable_ir", 32'(ir), 32'(mem[pc_save]));

      // Random traffic with variable memory latency
      wcnt = 0;
      late_ack = 0;
      for (int c = 0; c < 3000; c++) begin
         r_n = ($urandom_range(0, 99) >= 2);
         en  = ($urandom_range(0, 9) != 0);
         rd  = ($urandom_range(0, 9) < 3);
         sel = 1'($urandom);
         inc = ($urandom_range(0, 9) < 3);
         jmp = 1'($urandom);
         az  = 1'($urandom);
         ack = 0;
         if (en) begin
            if (m_pending) begin
               if (wcnt == 0) ack = 1;
               else           wcnt--;
            end else begin
               ack = late_ack || ($urandom_range(0, 19) == 0);
            end
         end
         late_ack = !r_n && m_pending;
         if (!m_pending) wcnt = $urandom_range(0, 4);
         step(r_n, en, rd, sel, inc, jmp, az, ack);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
